fios_3a_result_collector: RTL and testbench



---
 rtl/fios_3a_pkg.sv | 17 +
 rtl/fios_3a_valid_delay.sv | 34 +++
 rtl/fios_3a_result_collector.sv | 150 +++++++++++++++
 tb/tb_fios_3a_result_collector.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fios_3a_pkg.sv
// Shared types and sizing helpers for the FIOS 3A DSP result collector.
package fios_3a_pkg;

  localparam int unsigned WORD_WIDTH = 17;
  localparam int unsigned P_WIDTH    = 34;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } state_e;

  function automatic int unsigned result_width(int unsigned num_words);
    return (num_words + 1) * WORD_WIDTH;
  endfunction

endpackage

// File: rtl/fios_3a_valid_delay.sv
// {valid, last} shift register matching the DSP48 issue-to-P latency.
module fios_3a_valid_delay #(
  parameter int unsigned DSP_REG_LEVEL = 3
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);

  logic [DSP_REG_LEVEL-1:0] valid_q;
  logic [DSP_REG_LEVEL-1:0] last_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      // last only means something alongside an issue
      last_q[0]  <= valid_i & last_i;
      for (int i = 1; i < DSP_REG_LEVEL; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DSP_REG_LEVEL-1];
  assign last_o  = last_q[DSP_REG_LEVEL-1];

endmodule

// File: rtl/fios_3a_result_collector.sv
// Collects DSP48 P outputs into a parallel (NUM_WORDS+1)x17-bit result with done/ack handshake.
// Define RESULT_CARRY_CHAIN_EN to propagate the inter-word carry here rather than via the C port.
module fios_3a_result_collector
  import fios_3a_pkg::*;
#(
  parameter int unsigned NUM_WORDS     = 16,
  parameter int unsigned DSP_REG_LEVEL = 3
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               issue_i,
  input  logic                               last_i,
  input  logic [P_WIDTH-1:0]                 P_i,
  input  logic                               result_ack_i,
  output logic [WORD_WIDTH-1:0]              word_o,
  output logic                               word_valid_o,
  output logic [result_width(NUM_WORDS)-1:0] result_o,
  output logic                               done_o,
  output logic                               err_o
);

  localparam int unsigned     ResW    = result_width(NUM_WORDS);
  localparam int unsigned     CntW    = $clog2(NUM_WORDS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(NUM_WORDS);
  localparam logic [CntW-1:0] CntLast = CntW'(NUM_WORDS - 1);

  logic                  p_valid, p_last;
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_base, last_idx;
  logic [ResW-1:0]       result_q, result_d;
  logic [WORD_WIDTH-1:0] word_q, word_d, lo_word, top_word;
  logic                  word_valid_q, word_valid_d;
  logic                  err_q, err_d;
  logic                  start, accept, full, take, top_ovf;

  fios_3a_valid_delay #(
    .DSP_REG_LEVEL(DSP_REG_LEVEL)
  ) u_valid_delay (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .valid_i(issue_i),
    .last_i (last_i),
    .valid_o(p_valid),
    .last_o (p_last)
  );

  // cnt_q is the index of the next free word slot; CntFull means all data slots are used
  assign start    = p_valid && ((state_q == StIdle) || ((state_q == StDone) && result_ack_i));
  assign accept   = p_valid && (start || (state_q == StCollect));
  assign cnt_base = start ? '0 : cnt_q;
  assign full     = (cnt_base == CntFull);
  assign take     = accept && (!full || p_last);
  assign last_idx = full ? CntLast : cnt_base;

`ifdef RESULT_CARRY_CHAIN_EN
  logic [WORD_WIDTH:0] carry_q, carry_d, carry_base, sum;

  assign carry_base = start ? '0 : carry_q;
  assign sum        = {1'b0, P_i[WORD_WIDTH-1:0]} + carry_base;
  assign carry_d    = {1'b0, P_i[P_WIDTH-1:WORD_WIDTH]} + {{WORD_WIDTH{1'b0}}, sum[WORD_WIDTH]};
  assign lo_word    = sum[WORD_WIDTH-1:0];
  assign top_word   = carry_d[WORD_WIDTH-1:0];
  assign top_ovf    = carry_d[WORD_WIDTH];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      carry_q <= '0;
    end else if (take) begin
      carry_q <= carry_d;
    end
  end
`else
  assign lo_word  = P_i[WORD_WIDTH-1:0];
  assign top_word = P_i[P_WIDTH-1:WORD_WIDTH];
  assign top_ovf  = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    err_d        = err_q;

    if (start) begin
      result_d = '0;
    end
    if (p_valid && (state_q == StDone) && !result_ack_i) begin
      err_d = 1'b1;
    end
    if (!p_valid && (state_q == StDone) && result_ack_i) begin
      state_d = StIdle;
    end
    if (accept && !take) begin
      err_d = 1'b1;
    end

    if (take) begin
      word_d       = lo_word;
      word_valid_d = 1'b1;
      if (full) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_base + CntW'(1);
      end
      for (int unsigned k = 0; k <= NUM_WORDS; k++) begin
        if (!full && (k == 32'(cnt_base))) begin
          result_d[k*WORD_WIDTH +: WORD_WIDTH] = lo_word;
        end
        if (p_last && (k == 32'(last_idx) + 32'd1)) begin
          result_d[k*WORD_WIDTH +: WORD_WIDTH] = top_word;
        end
      end
      if (p_last) begin
        state_d = StDone;
        if (top_ovf) begin
          err_d = 1'b1;
        end
      end else begin
        state_d = StCollect;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      result_q     <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign result_o     = result_q;
  assign done_o       = (state_q == StDone);
  assign err_o        = err_q;

endmodule

// File: tb/tb_fios_3a_result_collector.sv
// Scoreboard bench for fios_3a_result_collector; expectations follow RESULT_CARRY_CHAIN_EN.
module tb_fios_3a_result_collector;

  localparam int unsigned NW = 16;
  localparam int unsigned RW = (NW + 1) * 17;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          issue_i = 1'b0;
  logic          last_i = 1'b0;
  logic [33:0]   P_i;
  logic          result_ack_i = 1'b0;
  logic [16:0]   word_o;
  logic          word_valid_o;
  logic [RW-1:0] result_o;
  logic          done_o;
  logic          err_o;

  fios_3a_result_collector #(
    .NUM_WORDS    (NW),
    .DSP_REG_LEVEL(3)
  ) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .issue_i     (issue_i),
    .last_i      (last_i),
    .P_i         (P_i),
    .result_ack_i(result_ack_i),
    .word_o      (word_o),
    .word_valid_o(word_valid_o),
    .result_o    (result_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clock_i = ~clock_i;

  // DSP model: P for an operand issued in cycle t appears in cycle t+3
  logic [33:0] p_cur = '0;
  logic [33:0] p_sh[3];
  always @(posedge clock_i) begin
    p_sh[0] <= p_cur;
    p_sh[1] <= p_sh[0];
    p_sh[2] <= p_sh[1];
  end
  assign P_i = p_sh[2];

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            wv_cyc = 0;
  logic [16:0]   exp_q[$];
  logic [16:0]   exp_w;
  logic [RW-1:0] exp_res;

  always @(negedge clock_i) begin
    if (word_valid_o) begin
      wv_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL word_unexpected: got %h, no word expected", word_o);
      end else begin
        exp_w = exp_q.pop_front();
        if (word_o !== exp_w) begin
          n_bad++;
          $display("FAIL word: got %h, expected %h", word_o, exp_w);
        end
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_w(input int k, input logic [16:0] v);
    exp_res[k*17 +: 17] = v;
  endtask

  task automatic drive(input logic [33:0] p, input logic last);
    issue_i = 1'b1;
    last_i  = last;
    p_cur   = p;
    @(posedge clock_i);
    #1;
    issue_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  task automatic ack();
    result_ack_i = 1'b1;
    @(posedge clock_i);
    #1;
    result_ack_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 40) begin
      @(negedge clock_i);
      n++;
    end
    #1;
    if (!done_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: done_o got 0, expected 1 within 40 cycles", name);
    end
  endtask

  task automatic reset_op(input string name);
    reset_i = 1'b1;
    @(negedge clock_i);
    chkv({name, "_result"}, result_o, '0);
    chkv({name, "_word"}, RW'(word_o), '0);
    chk1({name, "_wvalid"}, word_valid_o, 1'b0);
    chk1({name, "_done"}, done_o, 1'b0);
    chk1({name, "_err"}, err_o, 1'b0);
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clock_i);
    reset_op("reset");

    // Latency: single last word, low 5, high 2
    c0 = cyc;
    exp_q.push_back(17'h00005);
    drive({17'h00002, 17'h00005}, 1'b1);
    wait_done("lat");
    chki("lat_cycles", wv_cyc - c0, 4);
    exp_res = '0;
    set_w(0, 17'h00005);
    set_w(1, 17'h00002);
    chkv("lat_result", result_o, exp_res);
    chk1("lat_err", err_o, 1'b0);
    idle(3);
    chk1("lat_done_held", done_o, 1'b1);
    ack();
    @(negedge clock_i);
    chk1("lat_done_drop", done_o, 1'b0);

    // Full run: 16 back-to-back words 0..15
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(17'(i));
      drive({17'h0, 17'(i)}, i == 15);
    end
    wait_done("full");
    exp_res = '0;
    for (int i = 0; i < 16; i++) set_w(i, 17'(i));
    chkv("full_result", result_o, exp_res);
    chk1("full_err", err_o, 1'b0);
    idle(4);
    chk1("full_done_held", done_o, 1'b1);
    chkv("full_result_stable", result_o, exp_res);
    ack();
    @(negedge clock_i);
    chk1("full_done_drop", done_o, 1'b0);

    // Carry: all-ones P twice
    exp_res = '0;
`ifdef RESULT_CARRY_CHAIN_EN
    exp_q.push_back(17'h1FFFF);
    exp_q.push_back(17'h1FFFE);
    set_w(0, 17'h1FFFF);
    set_w(1, 17'h1FFFE);
    set_w(2, 17'h00000);
`else
    exp_q.push_back(17'h1FFFF);
    exp_q.push_back(17'h1FFFF);
    set_w(0, 17'h1FFFF);
    set_w(1, 17'h1FFFF);
    set_w(2, 17'h1FFFF);
`endif
    drive(34'h3_FFFF_FFFF, 1'b0);
    drive(34'h3_FFFF_FFFF, 1'b1);
    wait_done("carry");
    chkv("carry_result", result_o, exp_res);
`ifdef RESULT_CARRY_CHAIN_EN
    chk1("carry_err", err_o, 1'b1);
`else
    chk1("carry_err", err_o, 1'b0);
`endif
    ack();
    reset_op("reset2");

    // Protocol: word in DONE without ack is dropped
    exp_q.push_back(17'h00003);
    drive({17'h0, 17'h00003}, 1'b1);
    wait_done("proto");
    drive({17'h00005, 17'h00009}, 1'b1);
    idle(5);
    exp_res = '0;
    set_w(0, 17'h00003);
    chkv("proto_result_kept", result_o, exp_res);
    chk1("proto_err", err_o, 1'b1);
    chk1("proto_done", done_o, 1'b1);
    // Ack lands in the same cycle as the next P valid
    exp_q.push_back(17'h00011);
    drive({17'h0, 17'h00011}, 1'b0);
    idle(2);
    ack();
    @(negedge clock_i);
    chk1("proto_ack_done_drop", done_o, 1'b0);
    exp_res = '0;
    set_w(0, 17'h00011);
    chkv("proto_new_op_cleared", result_o, exp_res);
    exp_q.push_back(17'h00022);
    drive({17'h0, 17'h00022}, 1'b1);
    wait_done("proto2");
    set_w(1, 17'h00022);
    chkv("proto_new_op_result", result_o, exp_res);
    ack();
    reset_op("reset3");

    // Overflow: 17 data words before the last one
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(17'(32'h100 + i));
      drive({17'h0, 17'(32'h100 + i)}, 1'b0);
    end
    exp_q.push_back(17'h00055);
    drive({17'h00007, 17'h00055}, 1'b1);
    wait_done("ovf");
    exp_res = '0;
    for (int i = 0; i < 16; i++) set_w(i, 17'(32'h100 + i));
    set_w(16, 17'h00007);
    chkv("ovf_result", result_o, exp_res);
    chk1("ovf_err", err_o, 1'b1);
    ack();
    reset_op("reset4");

    // Reset mid-operation: only the first word is seen before reset hits
    exp_q.push_back(17'h00001);
    for (int i = 1; i <= 5; i++) drive({17'h0, 17'(i)}, 1'b0);
    reset_op("reset_mid");
    idle(6);
    chki("reset_mid_queue", exp_q.size(), 0);
    exp_q.delete();
    exp_q.push_back(17'h0000A);
    exp_q.push_back(17'h0000B);
    drive({17'h0, 17'h0000A}, 1'b0);
    drive({17'h00001, 17'h0000B}, 1'b1);
    wait_done("post_reset");
    exp_res = '0;
    set_w(0, 17'h0000A);
    set_w(1, 17'h0000B);
    set_w(2, 17'h00001);
    chkv("post_reset_result", result_o, exp_res);
    chk1("post_reset_err", err_o, 1'b0);
    ack();
    idle(3);
    chki("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
